// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and main memory.
// slave  : arbiter view (requests in, responses out, memory request out).
// master : environment view (requesters and memory model).
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned WDATA_W = 32,
    parameter int unsigned LINE_W  = 512
);
    // Port 0: L1 cache controller
    logic [ADDR_W-1:0]  req0_addr;
    logic [WDATA_W-1:0] req0_wdata;
    logic               req0_rd;
    logic               req0_wr;
    logic [LINE_W-1:0]  req0_rdata;
    logic               req0_ready;
    logic               req0_err;

    // Port 1: MMU page-table walker
    logic [ADDR_W-1:0]  req1_addr;
    logic [WDATA_W-1:0] req1_wdata;
    logic               req1_rd;
    logic               req1_wr;
    logic [LINE_W-1:0]  req1_rdata;
    logic               req1_ready;
    logic               req1_err;

    // Main-memory port
    logic [ADDR_W-1:0]  main_mem_addr;
    logic [WDATA_W-1:0] main_mem_data_out;
    logic               main_mem_read_req;
    logic               main_mem_write_req;
    logic [LINE_W-1:0]  main_mem_data_in;
    logic               main_mem_ready;

    modport slave (
        input  req0_addr, req0_wdata, req0_rd, req0_wr,
        output req0_rdata, req0_ready, req0_err,
        input  req1_addr, req1_wdata, req1_rd, req1_wr,
        output req1_rdata, req1_ready, req1_err,
        output main_mem_addr, main_mem_data_out, main_mem_read_req, main_mem_write_req,
        input  main_mem_data_in, main_mem_ready
    );

    modport master (
        output req0_addr, req0_wdata, req0_rd, req0_wr,
        input  req0_rdata, req0_ready, req0_err,
        output req1_addr, req1_wdata, req1_rd, req1_wr,
        input  req1_rdata, req1_ready, req1_err,
        input  main_mem_addr, main_mem_data_out, main_mem_read_req, main_mem_write_req,
        output main_mem_data_in, main_mem_ready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the main-memory port between the L1 cache controller
// (port 0) and the MMU page-table walker (port 1), one transaction at a time.
// Flow per transaction: IDLE (grant + latch) -> BUSY (request held until memory
// ready) -> RESP (one-cycle ready pulse to the owner) -> IDLE.
// Optional feature macro: MEMARB_TIMEOUT_EN enables a BUSY watchdog that aborts
// after TIMEOUT_CYC cycles and reports reqN_err with the ready pulse.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned WDATA_W       = 32,
    parameter int unsigned LINE_W        = 512,
    parameter int unsigned PRIORITY_MODE = 0,
    parameter int unsigned TIMEOUT_CYC   = 255
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               last_grant_q, last_grant_d;  // index of the last granted port
    logic               owner_q, owner_d;
    logic               op_wr_q, op_wr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [WDATA_W-1:0] wdata_q, wdata_d;
    logic               mem_rd_q, mem_rd_d;
    logic               mem_wr_q, mem_wr_d;
    logic [LINE_W-1:0]  rdata0_q, rdata0_d;
    logic [LINE_W-1:0]  rdata1_q, rdata1_d;
    logic               ready0_q, ready0_d;
    logic               ready1_q, ready1_d;
    logic               err0_q, err0_d;
    logic               err1_q, err1_d;

    logic               want0, want1, grant_any, grant_sel;
    logic [ADDR_W-1:0]  sel_addr;
    logic [WDATA_W-1:0] sel_wdata;
    logic               sel_wr;
    logic               wd_expire;

    // Request decode and arbitration for the IDLE cycle.
    always_comb begin
        want0     = bus.req0_rd | bus.req0_wr;
        want1     = bus.req1_rd | bus.req1_wr;
        grant_any = want0 | want1;
        if (want0 && want1) begin
            if (PRIORITY_MODE == 1) begin
                grant_sel = 1'b0;
            end else begin
                grant_sel = ~last_grant_q;
            end
        end else begin
            grant_sel = want1;
        end
        sel_addr  = grant_sel ? bus.req1_addr  : bus.req0_addr;
        sel_wdata = grant_sel ? bus.req1_wdata : bus.req0_wdata;
        // wr wins when both rd and wr are raised on one port
        sel_wr    = grant_sel ? bus.req1_wr    : bus.req0_wr;
    end

`ifdef MEMARB_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT_CYC + 1) > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [CntW-1:0] wd_cnt_q, wd_cnt_d;

    // Watchdog: counts BUSY cycles without memory ready, fires on reaching TIMEOUT_CYC.
    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        wd_expire = 1'b0;
        if (state_q != StBusy) begin
            wd_cnt_d = '0;
        end else if (!bus.main_mem_ready) begin
            if (wd_cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
                wd_expire = 1'b1;
            end else begin
                wd_cnt_d = wd_cnt_q + 1'b1;
            end
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    // Next-state and datapath updates for the transaction FSM.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        op_wr_d      = op_wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mem_rd_d     = mem_rd_q;
        mem_wr_d     = mem_wr_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        ready0_d     = 1'b0;
        ready1_d     = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;

        case (state_q)
            StIdle: begin
                if (grant_any) begin
                    owner_d      = grant_sel;
                    last_grant_d = grant_sel;
                    op_wr_d      = sel_wr;
                    addr_d       = sel_addr;
                    wdata_d      = sel_wdata;
                    mem_rd_d     = ~sel_wr;
                    mem_wr_d     = sel_wr;
                    state_d      = StBusy;
                end
            end
            StBusy: begin
                // A ready in the same cycle as the watchdog wins
                if (bus.main_mem_ready) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    state_d  = StResp;
                    if (owner_q) begin
                        ready1_d = 1'b1;
                        if (!op_wr_q) begin
                            rdata1_d = bus.main_mem_data_in;
                        end
                    end else begin
                        ready0_d = 1'b1;
                        if (!op_wr_q) begin
                            rdata0_d = bus.main_mem_data_in;
                        end
                    end
                end else if (wd_expire) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    state_d  = StResp;
                    if (owner_q) begin
                        ready1_d = 1'b1;
                        err1_d   = 1'b1;
                    end else begin
                        ready0_d = 1'b1;
                        err0_d   = 1'b1;
                    end
                end
            end
            StResp: begin
                // Ready pulse is live this cycle; back to IDLE to resample requests
                state_d = StIdle;
            end
            default: begin
                state_d  = StIdle;
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything and favours port 0 on the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            op_wr_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            ready0_q     <= 1'b0;
            ready1_q     <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            op_wr_q      <= op_wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            ready0_q     <= ready0_d;
            ready1_q     <= ready1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
        end
    end

    assign bus.main_mem_addr      = addr_q;
    assign bus.main_mem_data_out  = wdata_q;
    assign bus.main_mem_read_req  = mem_rd_q;
    assign bus.main_mem_write_req = mem_wr_q;
    assign bus.req0_rdata         = rdata0_q;
    assign bus.req1_rdata         = rdata1_q;
    assign bus.req0_ready         = ready0_q;
    assign bus.req1_ready         = ready1_q;
    assign bus.req0_err           = err0_q;
    assign bus.req1_err           = err1_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between two requesters: port 0 is the L1 cache controller (line refill and write-through) and port 1 is the MMU page-table walker.
- One transaction is in flight at a time.
- Each transaction is granted, latched, issued downstream and held until memory acknowledges. The response is then returned to the owning requester.
- Sits between the requesters and main memory, and presents the same main-memory signalling the cache controller uses today.

Parameters:
ADDR_W, 32, address width
WDATA_W, 32, write data width (single word, write-through)
LINE_W, 512, read line width returned by memory
PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority to port 0
TIMEOUT_CYC, 255, watchdog limit in cycles (used only with MEMARB_TIMEOUT_EN)

Ports:
clk  in  1  clock, all logic on the rising edge
rst  in  1  synchronous reset, active-high
req0_addr  in  ADDR_W  port 0 address
req0_wdata  in  WDATA_W  port 0 write data
req0_rd  in  1  port 0 read request (level)
req0_wr  in  1  port 0 write request (level)
req0_rdata  out  LINE_W  port 0 read line
req0_ready  out  1  port 0 completion pulse
req0_err  out  1  port 0 timeout error pulse
req1_addr, req1_wdata, req1_rd, req1_wr, req1_rdata, req1_ready, req1_err: same as port 0, for port 1
main_mem_addr  out  ADDR_W  address to memory
main_mem_data_out  out  WDATA_W  write data to memory
main_mem_read_req  out  1  memory read request (level)
main_mem_write_req  out  1  memory write request (level)
main_mem_data_in  in  LINE_W  line from memory
main_mem_ready  in  1  memory completion (one-cycle pulse)

Behaviour:
- Reset (synchronous, active-high): every output goes to 0, state goes to IDLE, last_grant = 1 (port 0 wins the first tie), watchdog counter = 0.
- State machine: IDLE -> BUSY -> RESP -> IDLE.
- IDLE:
  - A port is requesting if its rd or wr is high.
  - If only one port is requesting, grant it.
  - If both are requesting: with PRIORITY_MODE=0, grant the port that is not last_grant; with PRIORITY_MODE=1, grant port 0.
  - On grant, latch addr, wdata, op and owner; update last_grant; move to BUSY.
- BUSY:
  - main_mem_addr and main_mem_data_out are driven from the latched values.
  - Exactly one of read_req/write_req is high, from the registered output; it stays stable until main_mem_ready.
  - When main_mem_ready is sampled high: latch main_mem_data_in into the owner's rdata (reads only), drop read_req/write_req and move to RESP.
- RESP:
  - Owner's reqN_ready = 1 for exactly one cycle; the memory request stays low.
  - Next state is IDLE.
- Latency:
  - Request seen at edge t -> main-memory request high from cycle t+1.
  - main_mem_ready in cycle m -> reqN_ready and rdata valid in cycle m+1.
  - Next grant is sampled at the end of cycle m+2 -> next memory request in cycle m+3.
  - Memory request is therefore low for at least 2 cycles between transactions, so the memory cannot double-trigger.
- Requesters hold rd/wr until their ready pulse and drop them in the cycle after it. A request still high in IDLE is treated as a new transaction.
- rd and wr both high on one port: treated as a write.
- Requester drops its request mid-transaction: the transaction still completes and the ready pulse is still issued.
- main_mem_ready outside BUSY: ignored.
- reqN_rdata holds its last value until the next read completion for that port; the rdata of the non-owning port is unchanged.
- Reset mid-transaction: the next edge forces IDLE with all outputs 0. A memory ready arriving later is ignored (not in BUSY).
- reqN_err is 0 whenever MEMARB_TIMEOUT_EN is undefined.

Optional Feature:
- Macro: MEMARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without main_mem_ready.
  - When the counter reaches TIMEOUT_CYC, drop the memory request and go to RESP.
  - In RESP, the owner gets reqN_ready=1 together with reqN_err=1 (one cycle); rdata is unchanged.
  - main_mem_ready sampled in the same cycle as the timeout: the ready wins and the completion is normal.
- Undefined: no counter exists, BUSY waits indefinitely and the err outputs are tied to 0.

Test Plan:
1. Port 0 read 0x00001000; memory ready 3 cycles after the request, data {16{32'h00001000}} -> main_mem_read_req high for exactly 3 cycles; req0_ready one cycle later with req0_rdata={16{32'h00001000}}; req1 outputs stay 0.
2. Same cycle: port 0 read 0x2000 and port 1 write 0x3000 / 0xDEADBEEF, PRIORITY_MODE=0 -> port 0 read issued first; then main_mem_write_req with addr 0x3000 and data_out 0xDEADBEEF; req1_ready follows.
3. Both ports requesting continuously for 4 transactions -> PRIORITY_MODE=0 grants 0,1,0,1; PRIORITY_MODE=1 grants 0,0,0,0 and port 1 is never granted.
4. Port 1 with rd=wr=1 at 0x4000 -> only main_mem_write_req asserted; req1_ready pulses, req1_rdata unchanged.
5. rst asserted in the 2nd cycle of BUSY, memory ready 2 cycles later -> all outputs 0 on the next edge; no reqN_ready pulse; the late ready is ignored.
6. MEMARB_TIMEOUT_EN defined, TIMEOUT_CYC=8, memory never ready -> request drops after 8 BUSY cycles; req0_ready=req0_err=1 for one cycle; a following transaction completes normally.
